// File: rtl/gol_lcd_pkg.sv
// Shared types and constants for the Game-of-Life HD44780 renderer: FSM states,
// glyphs, LCD commands, row base addresses and the init command ROM.
package gol_lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, ROW_ADDR, CELLS, DONE
  } gol_state_e;

  typedef enum logic [2:0] {
    TX_PWR, TX_IDLE, TX_SETUP, TX_EHI, TX_GAP
  } tx_phase_e;

  localparam logic [7:0] GLYPH_ALIVE  = 8'h23;
  localparam logic [7:0] GLYPH_DEAD   = 8'h2E;
  localparam logic [7:0] GLYPH_SEL_AL = 8'h40;
  localparam logic [7:0] GLYPH_SEL_DD = 8'h5F;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input logic [1:0] y);
    case (y)
      2'd0:    return CMD_DDRAM | 8'h00;
      2'd1:    return CMD_DDRAM | 8'h40;
      2'd2:    return CMD_DDRAM | 8'h14;
      default: return CMD_DDRAM | 8'h54;
    endcase
  endfunction

  function automatic logic [7:0] cell_glyph(input logic alive, input logic sel);
    if (sel) return alive ? GLYPH_SEL_AL : GLYPH_SEL_DD;
    return alive ? GLYPH_ALIVE : GLYPH_DEAD;
  endfunction

endpackage

// File: rtl/gol_lcd_renderer_byte_tx.sv
// One LCD bus write: SETUP / E-high / gap timing plus the shared delay counter,
// which also times the power-up wait straight out of reset.
module gol_lcd_byte_tx
  import gol_lcd_pkg::*;
#(
  parameter int E_HIGH_CYC    = 12,
  parameter int CMD_GAP_CYC   = 2000,
  parameter int CLEAR_GAP_CYC = 80000,
  parameter int INIT_WAIT_CYC = 750000,
  parameter int CW            = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_gap,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  tx_phase_e       r_phase;
  logic [CW-1:0]   r_cnt;
  logic            r_e, r_rs, r_long;
  logic [7:0]      r_data;
  logic            w_done;

  // done fires in the last wait cycle so the next SETUP follows with no bubble
  assign w_done = ((r_phase == TX_PWR) || (r_phase == TX_GAP)) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= TX_PWR;
      r_cnt   <= CW'(INIT_WAIT_CYC - 1);
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_long  <= 1'b0;
    end else if (start && ((r_phase == TX_IDLE) || w_done)) begin
      r_phase <= TX_SETUP;
      r_rs    <= rs;
      r_data  <= data;
      r_long  <= long_gap;
      r_e     <= 1'b0;
    end else begin
      case (r_phase)
        TX_PWR:
          if (r_cnt == '0) r_phase <= TX_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        TX_SETUP: begin
          r_phase <= TX_EHI;
          r_cnt   <= CW'(E_HIGH_CYC - 1);
          r_e     <= 1'b1;
        end
        TX_EHI:
          if (r_cnt == '0) begin
            r_phase <= TX_GAP;
            r_e     <= 1'b0;
            r_cnt   <= r_long ? CW'(CLEAR_GAP_CYC - 1) : CW'(CMD_GAP_CYC - 1);
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        TX_GAP:
          if (r_cnt == '0) r_phase <= TX_IDLE;
          else             r_cnt   <= r_cnt - CW'(1);
        default: r_phase <= TX_IDLE;
      endcase
    end
  end

  assign done     = w_done;
  assign lcd_rs   = r_rs;
  assign lcd_e    = r_e;
  assign lcd_data = r_data;

endmodule

// File: rtl/gol_lcd_renderer.sv
// Snapshots the Game-of-Life grid per frame request and streams it to an HD44780 LCD.
// Optional selection cursor glyphs: define GOL_LCD_CURSOR_EN.
module gol_lcd_renderer
  import gol_lcd_pkg::*;
#(
  parameter int GRID_W        = 16,
  parameter int GRID_H        = 2,
  parameter int E_HIGH_CYC    = 12,
  parameter int CMD_GAP_CYC   = 2000,
  parameter int CLEAR_GAP_CYC = 80000,
  parameter int INIT_WAIT_CYC = 750000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_req,
  input  logic [GRID_W*GRID_H-1:0]   grid_i,
  input  logic [4:0]                 sel_x,
  input  logic [1:0]                 sel_y,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       lcd_rs,
  output logic                       lcd_rw,
  output logic                       lcd_e,
  output logic [7:0]                 lcd_data
);

  localparam int MAXD = (INIT_WAIT_CYC > CLEAR_GAP_CYC) ? INIT_WAIT_CYC : CLEAR_GAP_CYC;
  localparam int CW   = $clog2(MAXD + 1);
  localparam int XW   = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW   = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  gol_state_e                      r_state;
  logic                            r_busy, r_done, r_pend;
  logic [XW-1:0]                   r_x;
  logic [YW-1:0]                   r_y;
  logic [1:0]                      r_idx;
  logic [GRID_H-1:0][GRID_W-1:0]   r_snap;

  logic          w_tx_done, w_start, w_rs, w_long, w_go, w_last_x, w_last_y;
  logic          w_alive, w_sel;
  logic [7:0]    w_byte;
  logic [XW-1:0] w_cell_x;

  assign w_go     = (r_state == IDLE) && (frame_req || r_pend);
  assign w_last_x = (r_x == XW'(GRID_W - 1));
  assign w_last_y = (r_y == YW'(GRID_H - 1));
  // Byte launched on a done is the cell after the current one (x=0 right after the row address)
  assign w_cell_x = (r_state == CELLS) ? r_x + XW'(1) : '0;
  assign w_alive  = r_snap[r_y][w_cell_x];

`ifdef GOL_LCD_CURSOR_EN
  logic [4:0] r_sel_x;
  logic [1:0] r_sel_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_x <= '0;
      r_sel_y <= '0;
    end else if (w_go) begin
      r_sel_x <= sel_x;
      r_sel_y <= sel_y;
    end
  end

  assign w_sel = (r_sel_x == 5'(w_cell_x)) && (r_sel_y == 2'(r_y));
`else
  logic w_unused_sel;
  assign w_unused_sel = ^{sel_x, sel_y};
  assign w_sel        = 1'b0;
`endif

  always_comb begin
    w_start = 1'b0;
    w_rs    = 1'b0;
    w_byte  = 8'h00;
    case (r_state)
      PWR_WAIT: begin
        w_start = w_tx_done;
        w_byte  = init_rom(2'd0);
      end
      INIT: begin
        w_start = w_tx_done && (r_idx != 2'd3);
        w_byte  = init_rom(r_idx + 2'd1);
      end
      IDLE: begin
        w_start = w_go;
        w_byte  = row_cmd(2'd0);
      end
      ROW_ADDR: begin
        w_start = w_tx_done;
        w_rs    = 1'b1;
        w_byte  = cell_glyph(w_alive, w_sel);
      end
      CELLS: begin
        w_start = w_tx_done && !(w_last_x && w_last_y);
        if (w_last_x) begin
          w_byte = row_cmd(2'(r_y) + 2'd1);
        end else begin
          w_rs   = 1'b1;
          w_byte = cell_glyph(w_alive, w_sel);
        end
      end
      default: ;
    endcase
  end

  assign w_long = !w_rs && (w_byte == CMD_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PWR_WAIT;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
    end else begin
      r_done <= 1'b0;
      if (frame_req && (r_state != IDLE)) r_pend <= 1'b1;
      case (r_state)
        PWR_WAIT:
          if (w_tx_done) begin
            r_state <= INIT;
            r_idx   <= 2'd0;
          end
        INIT:
          if (w_tx_done) begin
            if (r_idx == 2'd3) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        IDLE:
          if (w_go) begin
            r_state <= ROW_ADDR;
            r_busy  <= 1'b1;
            r_pend  <= 1'b0;
            r_snap  <= grid_i;
            r_x     <= '0;
            r_y     <= '0;
          end
        ROW_ADDR:
          if (w_tx_done) begin
            r_state <= CELLS;
            r_x     <= '0;
          end
        CELLS:
          if (w_tx_done) begin
            if (!w_last_x) begin
              r_x <= r_x + XW'(1);
            end else if (w_last_y) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_y     <= r_y + YW'(1);
              r_state <= ROW_ADDR;
            end
          end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  gol_lcd_byte_tx #(
    .E_HIGH_CYC    (E_HIGH_CYC),
    .CMD_GAP_CYC   (CMD_GAP_CYC),
    .CLEAR_GAP_CYC (CLEAR_GAP_CYC),
    .INIT_WAIT_CYC (INIT_WAIT_CYC),
    .CW            (CW)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .rs       (w_rs),
    .data     (w_byte),
    .long_gap (w_long),
    .done     (w_tx_done),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  assign busy       = r_busy;
  assign frame_done = r_done;
  assign lcd_rw     = 1'b0;

endmodule
